ast_window_gen: RTL and testbench

- Parametrised successor to the fixed-size byte-window shifter feeding the bloom-filter hash stage.
- Accepts an Avalon-ST byte stream of AST_SINK_SYMBOLS bytes per beat.
- Emits one sliding window per symbol position per beat, with a runtime-selectable window length and per-packet history flush (or optional cross-packet history).
- Adds an output valid/ready handshake, empty-symbol masking and SOP/EOP passthrough.

---
 rtl/ast_window_pkg.sv | 33 +++
 rtl/ast_window_if.sv | 44 ++++
 rtl/ast_window_hist.sv | 67 ++++++
 rtl/ast_window_gen.sv | 133 +++++++++++++
 tb/tb_ast_window_gen.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ast_window_pkg.sv
`default_nettype none
// ============================================================================
// ast_window_pkg : shared types, widths and helpers for the window generator
// Rev 1.0
// ============================================================================
package ast_window_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_e;

  function automatic int empty_w(input int symbols);
    return (symbols == 1) ? 1 : $clog2(symbols);
  endfunction

  function automatic int win_w(input int window_max);
    return $clog2(window_max + 1);
  endfunction

  // Zero requests still yield a one-byte window; oversize requests saturate.
  function automatic int clamp_len(input int req, input int window_max);
    if (req == 0) return 1;
    if (req > window_max) return window_max;
    return req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ast_window_if.sv
`default_nettype none
// ============================================================================
// ast_window_if : Avalon-ST byte sink plus window output handshake bundle
// Rev 1.0
// ============================================================================
interface ast_window_if #(
  parameter int SYMBOLS    = 8,
  parameter int WINDOW_MAX = 20
);
  import ast_window_pkg::*;

  localparam int EMPTY_W = empty_w(SYMBOLS);
  localparam int WIN_W   = win_w(WINDOW_MAX);

  logic [SYMBOLS*BYTE_W-1:0]            ast_sink_data_i;
  logic                                 ast_sink_valid_i;
  logic                                 ast_sink_ready_o;
  logic [EMPTY_W-1:0]                   ast_sink_empty_i;
  logic                                 ast_sink_startofpacket_i;
  logic                                 ast_sink_endofpacket_i;
  logic [SYMBOLS*WINDOW_MAX*BYTE_W-1:0] windows_data_o;
  logic [SYMBOLS*WIN_W-1:0]             windows_valid_bytes_o;
  logic [SYMBOLS-1:0]                   windows_mask_o;
  logic                                 windows_sop_o;
  logic                                 windows_eop_o;
  logic                                 windows_valid_o;
  logic                                 windows_ready_i;

  modport slave (
    input  ast_sink_data_i, ast_sink_valid_i, ast_sink_empty_i,
           ast_sink_startofpacket_i, ast_sink_endofpacket_i, windows_ready_i,
    output ast_sink_ready_o, windows_data_o, windows_valid_bytes_o,
           windows_mask_o, windows_sop_o, windows_eop_o, windows_valid_o
  );

  modport master (
    output ast_sink_data_i, ast_sink_valid_i, ast_sink_empty_i,
           ast_sink_startofpacket_i, ast_sink_endofpacket_i, windows_ready_i,
    input  ast_sink_ready_o, windows_data_o, windows_valid_bytes_o,
           windows_mask_o, windows_sop_o, windows_eop_o, windows_valid_o
  );

endinterface
`default_nettype wire

// File: rtl/ast_window_hist.sv
`default_nettype none
// ============================================================================
// ast_window_hist : byte history shift register with saturating byte counter
// Rev 1.0
// ============================================================================
module ast_window_hist
  import ast_window_pkg::*;
#(
  parameter int SYMBOLS    = 8,
  parameter int WINDOW_MAX = 20,
  parameter int WIN_W      = 5
) (
  input  logic               clk_i,
  input  logic               srst_n_i,
  input  logic               clear_i,
  input  logic               insert_i,
  input  logic [SYMBOLS-1:0] sym_valid_i,
  input  byte_t              beat_i [SYMBOLS],
  output byte_t              vec_o  [SYMBOLS+WINDOW_MAX-1],
  output logic [WIN_W-1:0]   cnt_o
);

  localparam int HIST_N = WINDOW_MAX - 1;
  localparam int HIST_A = (HIST_N > 0) ? HIST_N : 1;

  byte_t            hist_q [HIST_A];
  byte_t            hist_d [HIST_A];
  logic [WIN_W-1:0] cnt_q;
  logic [WIN_W-1:0] cnt_d;
  int               n_ins;

  // vec_o[0] is the last beat byte in stream order, followed by older history.
  always_comb begin
    for (int s = 0; s < SYMBOLS; s++) begin
      vec_o[s] = beat_i[SYMBOLS-1-s];
    end
    for (int h = 0; h < HIST_N; h++) begin
      vec_o[SYMBOLS+h] = clear_i ? '0 : hist_q[h];
    end
    cnt_o = clear_i ? '0 : cnt_q;
  end

  always_comb begin
    n_ins = 0;
    for (int s = 0; s < SYMBOLS; s++) begin
      if (sym_valid_i[s]) n_ins++;
    end
    hist_d = hist_q;
    for (int h = 0; h < HIST_N; h++) begin
      hist_d[h] = vec_o[SYMBOLS-n_ins+h];
    end
    if (int'(cnt_o) + n_ins >= WINDOW_MAX) cnt_d = WIN_W'(WINDOW_MAX);
    else                                   cnt_d = WIN_W'(int'(cnt_o) + n_ins);
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      for (int h = 0; h < HIST_A; h++) hist_q[h] <= '0;
      cnt_q <= '0;
    end else if (insert_i) begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ast_window_gen.sv
`default_nettype none
// ============================================================================
// ast_window_gen : per-symbol sliding byte windows over an Avalon-ST stream
// Rev 1.0
// ============================================================================
module ast_window_gen
  import ast_window_pkg::*;
#(
  parameter int AST_SINK_SYMBOLS = 8,
  parameter int AST_SINK_ORDER   = 1,
  parameter int WINDOW_MAX       = 20,
  parameter int CROSS_PACKET     = 0
) (
  input  logic                            clk_i,
  input  logic                            srst_n_i,
  input  logic [$clog2(WINDOW_MAX+1)-1:0] win_len_i,
  ast_window_if.slave                     ast_if
);

  localparam int S     = AST_SINK_SYMBOLS;
  localparam int WIN_W = win_w(WINDOW_MAX);
  localparam int VEC_N = S + WINDOW_MAX - 1;
  localparam int DW    = S * WINDOW_MAX * BYTE_W;

  state_e             state_q;
  logic               valid_q;
  logic               sop_q;
  logic               eop_q;
  logic [S-1:0]       mask_q;
  logic [DW-1:0]      data_q;
  logic [DW-1:0]      data_d;
  logic [S*WIN_W-1:0] vb_q;
  logic [S*WIN_W-1:0] vb_d;
  logic [WIN_W-1:0]   len_q;
  logic [WIN_W-1:0]   len_d;
  logic [WIN_W-1:0]   cnt_pre;
  logic [S-1:0]       sym_valid;
  logic               sink_ready;
  logic               accept;
  logic               produce;
  logic               flush;
  byte_t              beat [S];
  byte_t              vec  [VEC_N];
  int                 n_valid;
  int                 lim;

  assign sink_ready = srst_n_i & (~valid_q | ast_if.windows_ready_i);
  assign accept     = ast_if.ast_sink_valid_i & sink_ready;
  // Beats outside a packet that do not open one are consumed silently.
  assign produce    = accept & (ast_if.ast_sink_startofpacket_i | (state_q == ST_IN_PKT));
  assign flush      = produce & ast_if.ast_sink_startofpacket_i & (CROSS_PACKET == 0);
  assign len_d      = ast_if.ast_sink_startofpacket_i
                      ? WIN_W'(clamp_len(int'(win_len_i), WINDOW_MAX)) : len_q;

  always_comb begin
    n_valid = S;
    if (ast_if.ast_sink_endofpacket_i) n_valid = S - int'(ast_if.ast_sink_empty_i);
    for (int s = 0; s < S; s++) begin
      sym_valid[s] = (s < n_valid);
      beat[s] = ast_if.ast_sink_data_i[((AST_SINK_ORDER != 0) ? (S-1-s) : s)*BYTE_W +: BYTE_W];
    end
  end

  ast_window_hist #(
    .SYMBOLS    (S),
    .WINDOW_MAX (WINDOW_MAX),
    .WIN_W      (WIN_W)
  ) u_hist (
    .clk_i       (clk_i),
    .srst_n_i    (srst_n_i),
    .clear_i     (flush),
    .insert_i    (produce),
    .sym_valid_i (sym_valid),
    .beat_i      (beat),
    .vec_o       (vec),
    .cnt_o       (cnt_pre)
  );

  // Window k ends at stream position k; element j sits at vec[S-1-k+j].
  always_comb begin
    data_d = '0;
    vb_d   = '0;
    lim    = 0;
    for (int k = 0; k < S; k++) begin
      if (sym_valid[k]) begin
        lim = int'(cnt_pre) + k + 1;
        if (lim > int'(len_d)) lim = int'(len_d);
        vb_d[k*WIN_W +: WIN_W] = WIN_W'(lim);
        for (int j = 0; j < WINDOW_MAX; j++) begin
          if (j < lim) data_d[(k*WINDOW_MAX+j)*BYTE_W +: BYTE_W] = vec[S-1-k+j];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      mask_q  <= '0;
      data_q  <= '0;
      vb_q    <= '0;
      len_q   <= WIN_W'(WINDOW_MAX);
    end else begin
      if (produce) begin
        len_q   <= len_d;
        state_q <= ast_if.ast_sink_endofpacket_i ? ST_IDLE : ST_IN_PKT;
      end
      if (sink_ready) begin
        valid_q <= produce;
        if (produce) begin
          data_q <= data_d;
          vb_q   <= vb_d;
          mask_q <= sym_valid;
          sop_q  <= ast_if.ast_sink_startofpacket_i;
          eop_q  <= ast_if.ast_sink_endofpacket_i;
        end
      end
    end
  end

  assign ast_if.ast_sink_ready_o      = sink_ready;
  assign ast_if.windows_valid_o       = valid_q;
  assign ast_if.windows_data_o        = data_q;
  assign ast_if.windows_valid_bytes_o = vb_q;
  assign ast_if.windows_mask_o        = mask_q;
  assign ast_if.windows_sop_o         = sop_q;
  assign ast_if.windows_eop_o         = eop_q;

endmodule
`default_nettype wire

// File: tb/tb_ast_window_gen.sv
`default_nettype none
// ============================================================================
// tb_ast_window_gen : scoreboard bench, two instances (history flushed / kept)
// Rev 1.0
// ============================================================================
module tb_ast_window_gen;

  localparam int S   = 8;
  localparam int WM  = 20;
  localparam int WW  = 5;
  localparam int EW  = 3;
  localparam int DW  = S * WM * 8;
  localparam int VBW = S * WW;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [VBW-1:0] vb;
    logic [S-1:0]   mask;
    logic           sop;
    logic           eop;
  } exp_t;

  logic           clk = 1'b0;
  logic           s_rst_n = 1'b0;
  logic [S*8-1:0] s_data = '0;
  logic           s_valid = 1'b0;
  logic [EW-1:0]  s_empty = '0;
  logic           s_sop = 1'b0;
  logic           s_eop = 1'b0;
  logic [WW-1:0]  s_wl = '0;
  logic           s_wready = 1'b1;
  int             rdy_mode = 0;

  int n_cmp = 0;
  int n_err = 0;

  exp_t q0[$];
  exp_t q1[$];

  logic [7:0] m_hist [2][64];
  int         m_cnt [2];
  int         m_len [2];
  bit         m_inpkt [2];

  always #5 clk = ~clk;

  ast_window_if #(.SYMBOLS(S), .WINDOW_MAX(WM)) if0 ();
  ast_window_if #(.SYMBOLS(S), .WINDOW_MAX(WM)) if1 ();

  assign if0.ast_sink_data_i          = s_data;
  assign if0.ast_sink_valid_i         = s_valid;
  assign if0.ast_sink_empty_i         = s_empty;
  assign if0.ast_sink_startofpacket_i = s_sop;
  assign if0.ast_sink_endofpacket_i   = s_eop;
  assign if0.windows_ready_i          = s_wready;
  assign if1.ast_sink_data_i          = s_data;
  assign if1.ast_sink_valid_i         = s_valid;
  assign if1.ast_sink_empty_i         = s_empty;
  assign if1.ast_sink_startofpacket_i = s_sop;
  assign if1.ast_sink_endofpacket_i   = s_eop;
  assign if1.windows_ready_i          = s_wready;

  ast_window_gen #(.AST_SINK_SYMBOLS(S), .AST_SINK_ORDER(1), .WINDOW_MAX(WM), .CROSS_PACKET(0))
    u_dut0 (.clk_i(clk), .srst_n_i(s_rst_n), .win_len_i(s_wl), .ast_if(if0));
  ast_window_gen #(.AST_SINK_SYMBOLS(S), .AST_SINK_ORDER(1), .WINDOW_MAX(WM), .CROSS_PACKET(1))
    u_dut1 (.clk_i(clk), .srst_n_i(s_rst_n), .win_len_i(s_wl), .ast_if(if1));

  // Reference model: keeps the stream bytes since history start, newest first.
  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_len[i] = WM;
      m_inpkt[i] = 1'b0;
      for (int h = 0; h < 64; h++) m_hist[i][h] = 8'h00;
    end
  endfunction

  function automatic bit model_step(input int inst, input logic [S*8-1:0] d, input bit sop,
                                    input bit eop, input int empty, input int wl, output exp_t e);
    int n;
    int lim;
    int p;
    e = '0;
    if (!sop && !m_inpkt[inst]) return 1'b0;
    if (sop) begin
      m_len[inst] = (wl == 0) ? 1 : ((wl > WM) ? WM : wl);
      if (inst == 0) begin
        m_cnt[inst] = 0;
        for (int h = 0; h < 64; h++) m_hist[inst][h] = 8'h00;
      end
    end
    n = eop ? (S - empty) : S;
    for (int k = 0; k < n; k++) begin
      p = S - 1 - k;
      for (int h = 63; h > 0; h--) m_hist[inst][h] = m_hist[inst][h-1];
      m_hist[inst][0] = d[p*8 +: 8];
      m_cnt[inst]++;
      lim = (m_cnt[inst] < m_len[inst]) ? m_cnt[inst] : m_len[inst];
      e.vb[k*WW +: WW] = WW'(lim);
      for (int j = 0; j < lim; j++) e.data[(k*WM+j)*8 +: 8] = m_hist[inst][j];
      e.mask[k] = 1'b1;
    end
    e.sop = sop;
    e.eop = eop;
    m_inpkt[inst] = !eop;
    return 1'b1;
  endfunction

  task automatic check_out(input int inst, input logic v, input logic r, input logic [DW-1:0] d,
                           input logic [VBW-1:0] vb, input logic [S-1:0] m, input logic so,
                           input logic eo);
    exp_t e;
    int   qs;
    int   kk;
    if (v !== 1'b1) return;
    n_cmp++;
    qs = (inst == 0) ? q0.size() : q1.size();
    if (qs == 0) begin
      n_err++;
      $display("FAIL dut%0d output_beat: got valid=1, required no pending beat", inst);
      return;
    end
    e = (inst == 0) ? q0[0] : q1[0];
    if ({d, vb, m, so, eo} !== {e.data, e.vb, e.mask, e.sop, e.eop}) begin
      n_err++;
      kk = 0;
      for (int k = S - 1; k >= 0; k--) begin
        if (d[k*WM*8 +: WM*8] !== e.data[k*WM*8 +: WM*8] || vb[k*WW +: WW] !== e.vb[k*WW +: WW])
          kk = k;
      end
      $display("FAIL dut%0d window%0d got data=%h vb=%0d mask=%b sop=%b eop=%b required data=%h vb=%0d mask=%b sop=%b eop=%b",
               inst, kk, d[kk*WM*8 +: WM*8], vb[kk*WW +: WW], m, so, eo,
               e.data[kk*WM*8 +: WM*8], e.vb[kk*WW +: WW], e.mask, e.sop, e.eop);
    end
    if (r === 1'b1) begin
      if (inst == 0) void'(q0.pop_front());
      else           void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (s_rst_n) begin
      check_out(0, if0.windows_valid_o, s_wready, if0.windows_data_o, if0.windows_valid_bytes_o,
                if0.windows_mask_o, if0.windows_sop_o, if0.windows_eop_o);
      check_out(1, if1.windows_valid_o, s_wready, if1.windows_data_o, if1.windows_valid_bytes_o,
                if1.windows_mask_o, if1.windows_sop_o, if1.windows_eop_o);
    end
  end

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       s_wready = 1'b1;
      2:       s_wready = 1'b0;
      default: s_wready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic send_beat(input logic [S*8-1:0] d, input bit sop, input bit eop,
                           input int empty, input int wl);
    int   t;
    bit   p0;
    bit   p1;
    exp_t e0;
    exp_t e1;
    t = 0;
    s_data  = d;
    s_sop   = sop;
    s_eop   = eop;
    s_empty = EW'(empty);
    s_wl    = WW'(wl);
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (if0.ast_sink_ready_o === 1'b1 && if1.ast_sink_ready_o === 1'b1) break;
      t++;
      if (t > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL sink_accept_timeout: got ready=0 for 200 clks, required ready=1");
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        return;
      end
    end
    p0 = model_step(0, d, sop, eop, empty, wl, e0);
    p1 = model_step(1, d, sop, eop, empty, wl, e1);
    if (p0) q0.push_back(e0);
    if (p1) q1.push_back(e1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    if (p0) begin
      n_cmp++;
      if (if0.windows_valid_o !== 1'b1) begin
        n_err++;
        $display("FAIL dut0 latency: got valid=%b one clk after accept, required 1", if0.windows_valid_o);
      end
    end
  endtask

  task automatic do_reset();
    s_rst_n = 1'b0;
    s_valid = 1'b0;
    q0.delete();
    q1.delete();
    model_reset();
    @(posedge clk);
    #1;
    n_cmp++;
    if ({if0.windows_valid_o, if0.windows_data_o, if0.windows_valid_bytes_o, if0.windows_mask_o,
         if0.windows_sop_o, if0.windows_eop_o, if0.ast_sink_ready_o} !== '0) begin
      n_err++;
      $display("FAIL dut0 reset_outputs: got valid=%b vb=%h mask=%b ready=%b, required all 0",
               if0.windows_valid_o, if0.windows_valid_bytes_o, if0.windows_mask_o, if0.ast_sink_ready_o);
    end
    n_cmp++;
    if ({if1.windows_valid_o, if1.windows_data_o, if1.windows_valid_bytes_o, if1.windows_mask_o,
         if1.windows_sop_o, if1.windows_eop_o, if1.ast_sink_ready_o} !== '0) begin
      n_err++;
      $display("FAIL dut1 reset_outputs: got valid=%b vb=%h mask=%b ready=%b, required all 0",
               if1.windows_valid_o, if1.windows_valid_bytes_o, if1.windows_mask_o, if1.ast_sink_ready_o);
    end
    s_rst_n = 1'b1;
  endtask

  // Beat whose stream-order bytes are first, first+1, ... (first byte in symbol S-1).
  function automatic logic [S*8-1:0] seq_beat(input int first);
    logic [S*8-1:0] d;
    for (int k = 0; k < S; k++) d[(S-1-k)*8 +: 8] = 8'(first + k);
    return d;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1);
  end

  initial begin
    int nb;
    int wl;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    repeat (2) @(posedge clk);
    #1;

    // 3-beat packet 01..18, len 4, then a 2-beat packet ending with empty=3
    send_beat(seq_beat(8'h01), 1, 0, 0, 4);
    send_beat(seq_beat(8'h09), 0, 0, 0, 4);
    send_beat(seq_beat(8'h11), 0, 1, 0, 4);
    send_beat(seq_beat(8'h21), 1, 0, 5, 6);
    send_beat(seq_beat(8'h29), 0, 1, 3, 6);

    // backpressure mid-packet for 5 clocks
    send_beat(seq_beat(8'h41), 1, 0, 0, 9);
    fork
      begin
        send_beat(seq_beat(8'h49), 0, 0, 0, 9);
        send_beat(seq_beat(8'h51), 0, 0, 0, 9);
        send_beat(seq_beat(8'h59), 0, 1, 2, 9);
      end
      begin
        #1;
        rdy_mode = 2;
        @(posedge clk);
        repeat (5) begin
          @(negedge clk);
          #2;
          n_cmp++;
          if (if0.ast_sink_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL stall_sink_ready: got %b, required 0", if0.ast_sink_ready_o);
          end
        end
        rdy_mode = 0;
      end
    join

    // window length clamp and mid-packet change
    send_beat(seq_beat(8'h61), 1, 1, 0, 0);
    send_beat(seq_beat(8'h71), 1, 0, 0, 25);
    send_beat(seq_beat(8'h79), 0, 1, 1, 2);
    send_beat(seq_beat(8'h81), 1, 0, 0, 3);
    send_beat(seq_beat(8'h89), 0, 1, 0, 17);

    // reset mid-packet, then a stray non-SOP beat, then a clean packet
    send_beat(seq_beat(8'h91), 1, 0, 0, 7);
    do_reset();
    send_beat(seq_beat(8'h99), 0, 0, 0, 7);
    send_beat(seq_beat(8'hA1), 1, 0, 0, 7);
    send_beat(seq_beat(8'hA9), 0, 1, 4, 7);

    // randomized traffic with random backpressure
    rdy_mode = 1;
    for (int pk = 0; pk < 60; pk++) begin
      if ($urandom_range(0, 5) == 0)
        send_beat({$urandom, $urandom}, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 31));
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        wl = $urandom_range(0, 31);
        send_beat({$urandom, $urandom}, b == 0,
                  (b == nb - 1) && ($urandom_range(0, 9) != 0), $urandom_range(0, 7), wl);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end

    rdy_mode = 0;
    for (int t = 0; t < 100; t++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(posedge clk);
    end
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d/%0d beats outstanding, required 0/0", q0.size(), q1.size());
    end
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
